// File: rtl/fcs_checker_wide.sv
// Ethernet FCS (CRC-32) checker for BYTES-lane receive beats; registered end-of-frame status.
// Define FCS_CHECKER_STATS_EN to add saturating good/bad frame counters.
module fcs_checker_wide #(
  parameter int unsigned BYTES           = 1,
  parameter logic [31:0] CRC_POLY        = 32'hEDB8_8320,  // reflected form of 0x04C11DB7
  parameter logic [31:0] CRC_INIT        = 32'hFFFF_FFFF,
  parameter logic [31:0] CRC_RESIDUE     = 32'hDEBB_20E3,
  parameter int unsigned MIN_FRAME_BYTES = 64,
  parameter int unsigned MAX_FRAME_BYTES = 1518,
  parameter int unsigned LEN_W           = 16,
  parameter int unsigned CNT_W           = 32,
  localparam int unsigned KEEP_W         = $clog2(BYTES) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [8*BYTES-1:0]  data_i,
  input  logic                valid_i,
  input  logic                sof_i,
  input  logic                eof_i,
  input  logic [KEEP_W-1:0]   keep_i,
  input  logic                abort_i,
  output logic                status_valid_o,
  output logic                fcs_error_o,
  output logic                runt_o,
  output logic                oversize_o,
  output logic                aborted_o,
  output logic [LEN_W-1:0]    frame_len_o
`ifdef FCS_CHECKER_STATS_EN
  ,
  output logic [CNT_W-1:0]    good_cnt_o,
  output logic [CNT_W-1:0]    bad_cnt_o
`endif
);

  localparam logic [KEEP_W-1:0] LANES   = KEEP_W'(BYTES);
  localparam logic [LEN_W-1:0]  MIN_LEN = LEN_W'(MIN_FRAME_BYTES);
  localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(MAX_FRAME_BYTES);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e            state_q, state_d;
  logic [31:0]       crc_q, crc_d;
  logic [LEN_W-1:0]  len_q, len_d;

  logic [KEEP_W-1:0] beat_bytes;
  logic              fresh;
  logic [31:0]       crc_fold;
  logic [LEN_W-1:0]  len_base;
  logic [LEN_W:0]    len_sum;
  logic [LEN_W-1:0]  len_fold;

  logic              done;
  logic              done_abort;
  logic [LEN_W-1:0]  done_len;
  logic              done_fcs_err;
  logic              done_runt;
  logic              done_over;

  logic              status_valid_q;
  logic              fcs_error_q;
  logic              runt_q;
  logic              oversize_q;
  logic              aborted_q;
  logic [LEN_W-1:0]  frame_len_q;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] r;
    r = crc ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Fold this beat into the CRC and length; a sof beat always starts from the preset.
  always_comb begin
    beat_bytes = LANES;
    if (eof_i && (keep_i != '0) && (keep_i <= LANES)) beat_bytes = keep_i;
    fresh    = (state_q == StIdle) || sof_i;
    crc_fold = fresh ? CRC_INIT : crc_q;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (KEEP_W'(i) < beat_bytes) crc_fold = crc_byte(crc_fold, data_i[8*i +: 8]);
    end
    len_base = fresh ? '0 : len_q;
    len_sum  = {1'b0, len_base} + (LEN_W+1)'(beat_bytes);
    len_fold = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    len_d      = len_q;
    done       = 1'b0;
    done_abort = 1'b0;
    done_len   = len_fold;
    case (state_q)
      StIdle: begin
        if (valid_i && sof_i) begin
          if (eof_i) begin
            done = 1'b1;
          end else begin
            state_d = StActive;
            crc_d   = crc_fold;
            len_d   = len_fold;
          end
        end
      end
      StActive: begin
        if (abort_i || (valid_i && sof_i)) begin
          // Old frame ends bad; its length excludes the terminating beat.
          done       = 1'b1;
          done_abort = 1'b1;
          done_len   = len_q;
          state_d    = StIdle;
          crc_d      = CRC_INIT;
          len_d      = '0;
          if (!abort_i && !eof_i) begin
            state_d = StActive;
            crc_d   = crc_fold;
            len_d   = len_fold;
          end
        end else if (valid_i) begin
          if (eof_i) begin
            done    = 1'b1;
            state_d = StIdle;
            crc_d   = CRC_INIT;
            len_d   = '0;
          end else begin
            crc_d = crc_fold;
            len_d = len_fold;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    done_fcs_err = done_abort || (crc_fold != CRC_RESIDUE);
    done_runt    = done_len < MIN_LEN;
    done_over    = done_len > MAX_LEN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      crc_q   <= CRC_INIT;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      len_q   <= len_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_valid_q <= 1'b0;
      fcs_error_q    <= 1'b0;
      runt_q         <= 1'b0;
      oversize_q     <= 1'b0;
      aborted_q      <= 1'b0;
      frame_len_q    <= '0;
    end else begin
      status_valid_q <= done;
      if (done) begin
        fcs_error_q <= done_fcs_err;
        runt_q      <= done_runt;
        oversize_q  <= done_over;
        aborted_q   <= done_abort;
        frame_len_q <= done_len;
      end
    end
  end

  assign status_valid_o = status_valid_q;
  assign fcs_error_o    = fcs_error_q;
  assign runt_o         = runt_q;
  assign oversize_o     = oversize_q;
  assign aborted_o      = aborted_q;
  assign frame_len_o    = frame_len_q;

`ifdef FCS_CHECKER_STATS_EN
  logic [CNT_W-1:0] good_q;
  logic [CNT_W-1:0] bad_q;
  logic             done_bad;

  assign done_bad = done_fcs_err | done_runt | done_over | done_abort;

  // Counters move on the same edge that raises the status strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_q <= '0;
      bad_q  <= '0;
    end else if (done) begin
      if (done_bad) begin
        if (bad_q != '1) bad_q <= bad_q + 1'b1;
      end else begin
        if (good_q != '1) good_q <= good_q + 1'b1;
      end
    end
  end

  assign good_cnt_o = good_q;
  assign bad_cnt_o  = bad_q;
`endif

endmodule

// File: tb/tb_fcs_checker_wide.sv
// Bench for fcs_checker_wide: three instances (1, 4 and 8 lanes) against a frame-level model
// that recomputes the CRC over each whole received frame.
module tb_fcs_checker_wide;

  typedef logic [7:0] bq_t [$];
  typedef struct packed {
    logic [1:0]  k;
    logic        fe;
    logic        ru;
    logic        ov;
    logic        ab;
    logic [15:0] len;
  } st_t;

  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0][63:0] d;
  logic [2:0]       v, s, e, a;
  logic [2:0][3:0]  kp;
  logic [2:0]       sv_o, fe_o, ru_o, ov_o, ab_o;
  logic [2:0][15:0] ln_o;
`ifdef FCS_CHECKER_STATS_EN
  logic [2:0][31:0] gc_o, bc_o;
`endif

  int   n_assert = 0;
  int   n_fail   = 0;
  int   ns       = 0;
  st_t  hist[$];
  st_t  c_st;

  fcs_checker_wide #(.BYTES(1), .MIN_FRAME_BYTES(0)) u1 (
    .clk(clk), .rst(rst), .data_i(d[0][7:0]), .valid_i(v[0]), .sof_i(s[0]), .eof_i(e[0]),
    .keep_i(kp[0][0:0]), .abort_i(a[0]), .status_valid_o(sv_o[0]), .fcs_error_o(fe_o[0]),
    .runt_o(ru_o[0]), .oversize_o(ov_o[0]), .aborted_o(ab_o[0]), .frame_len_o(ln_o[0])
`ifdef FCS_CHECKER_STATS_EN
    , .good_cnt_o(gc_o[0]), .bad_cnt_o(bc_o[0])
`endif
  );

  fcs_checker_wide #(.BYTES(4)) u4 (
    .clk(clk), .rst(rst), .data_i(d[1][31:0]), .valid_i(v[1]), .sof_i(s[1]), .eof_i(e[1]),
    .keep_i(kp[1][2:0]), .abort_i(a[1]), .status_valid_o(sv_o[1]), .fcs_error_o(fe_o[1]),
    .runt_o(ru_o[1]), .oversize_o(ov_o[1]), .aborted_o(ab_o[1]), .frame_len_o(ln_o[1])
`ifdef FCS_CHECKER_STATS_EN
    , .good_cnt_o(gc_o[1]), .bad_cnt_o(bc_o[1])
`endif
  );

  fcs_checker_wide #(.BYTES(8)) u8 (
    .clk(clk), .rst(rst), .data_i(d[2]), .valid_i(v[2]), .sof_i(s[2]), .eof_i(e[2]),
    .keep_i(kp[2]), .abort_i(a[2]), .status_valid_o(sv_o[2]), .fcs_error_o(fe_o[2]),
    .runt_o(ru_o[2]), .oversize_o(ov_o[2]), .aborted_o(ab_o[2]), .frame_len_o(ln_o[2])
`ifdef FCS_CHECKER_STATS_EN
    , .good_cnt_o(gc_o[2]), .bad_cnt_o(bc_o[2])
`endif
  );

  function automatic int lanes(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 8);
  endfunction

  function automatic int kmask(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 7 : 15);
  endfunction

  function automatic int min_len(input int k);
    return (k == 0) ? 0 : 64;
  endfunction

  // Reflected CRC-32, preset all-ones, no final inversion.
  function automatic logic [31:0] crc_of(input bq_t q);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic bq_t make_frame(input int n, input int seed);
    bq_t f;
    logic [31:0] c;
    for (int i = 0; i < n - 4; i++) f.push_back(8'((seed + 13 * i) ^ (i >> 3)));
    c = ~crc_of(f);
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    return f;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] got,
                     input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s u%0d: got 0x%0h, expected 0x%0h", nm, k, got, exp);
    end
  endtask

  // Frame-level model: collect each frame's bytes, judge it when it ends.
  logic             m_act [3];
  bq_t              fq [3];
  int               m_n, m_kk;
  logic [2:0]       x_sv, x_fe, x_ru, x_ov, x_ab;
  logic [2:0][15:0] x_ln;
  logic [2:0][31:0] x_gc, x_bc;

  task automatic push(input int k, input int n);
    for (int i = 0; i < n; i++) fq[k].push_back(d[k][8*i +: 8]);
  endtask

  task automatic finish(input int k, input logic ab);
    int l;
    logic [31:0] c;
    l = fq[k].size();
    if (l > 65535) l = 65535;
    c = crc_of(fq[k]);
    x_sv[k] = 1'b1;
    x_ab[k] = ab;
    x_fe[k] = ab || (c != RESIDUE);
    x_ru[k] = l < min_len(k);
    x_ov[k] = l > 1518;
    x_ln[k] = 16'(l);
    if (x_fe[k] || x_ru[k] || x_ov[k]) begin
      if (x_bc[k] != '1) x_bc[k] = x_bc[k] + 1;
    end else begin
      if (x_gc[k] != '1) x_gc[k] = x_gc[k] + 1;
    end
    fq[k] = {};
  endtask

  always @(posedge clk) begin
    if (rst) begin
      x_sv = '0; x_fe = '0; x_ru = '0; x_ov = '0; x_ab = '0; x_ln = '0;
      x_gc = '0; x_bc = '0;
      for (int k = 0; k < 3; k++) begin
        m_act[k] = 1'b0;
        fq[k] = {};
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        x_sv[k] = 1'b0;
        m_n  = lanes(k);
        m_kk = int'(kp[k]) & kmask(k);
        if (e[k] && m_kk >= 1 && m_kk <= lanes(k)) m_n = m_kk;
        if (m_act[k] && a[k]) begin
          finish(k, 1'b1);
          m_act[k] = 1'b0;
        end else if (v[k] && m_act[k] && s[k]) begin
          finish(k, 1'b1);
          m_act[k] = 1'b0;
          if (!e[k]) begin
            push(k, m_n);
            m_act[k] = 1'b1;
          end
        end else if (v[k] && (m_act[k] || s[k])) begin
          push(k, m_n);
          if (e[k]) begin
            finish(k, 1'b0);
            m_act[k] = 1'b0;
          end else begin
            m_act[k] = 1'b1;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        chk("status_valid", k, 32'(sv_o[k]), 32'(x_sv[k]));
        chk("fcs_error", k, 32'(fe_o[k]), 32'(x_fe[k]));
        chk("runt", k, 32'(ru_o[k]), 32'(x_ru[k]));
        chk("oversize", k, 32'(ov_o[k]), 32'(x_ov[k]));
        chk("aborted", k, 32'(ab_o[k]), 32'(x_ab[k]));
        chk("frame_len", k, 32'(ln_o[k]), 32'(x_ln[k]));
`ifdef FCS_CHECKER_STATS_EN
        chk("good_cnt", k, gc_o[k], x_gc[k]);
        chk("bad_cnt", k, bc_o[k], x_bc[k]);
`endif
        if (sv_o[k]) begin
          c_st.k   = 2'(k);
          c_st.fe  = fe_o[k];
          c_st.ru  = ru_o[k];
          c_st.ov  = ov_o[k];
          c_st.ab  = ab_o[k];
          c_st.len = ln_o[k];
          hist.push_back(c_st);
        end
      end
    end
  end

  task automatic send(input int k, input bq_t f, input int gap_after, input int end_beat,
                      input int end_mode, input int kovr, input bit tail_idle);
    int nb, nbeats;
    nb = lanes(k);
    nbeats = (f.size() + nb - 1) / nb;
    for (int i = 0; i < nbeats; i++) begin
      @(negedge clk);
      d[k] = '0;
      for (int j = 0; j < nb; j++) if (i * nb + j < f.size()) d[k][8*j +: 8] = f[i*nb + j];
      v[k] = 1'b1;
      s[k] = (i == 0);
      e[k] = (i == nbeats - 1);
      a[k] = 1'b0;
      kp[k] = e[k] ? 4'(f.size() - i * nb) : 4'(nb);
      if (e[k] && kovr >= 0) kp[k] = 4'(kovr);
      if (end_mode != 0 && i == end_beat) begin
        e[k]  = 1'b0;
        kp[k] = 4'(nb);
        a[k]  = (end_mode == 1);
        break;
      end
      if (i == gap_after) begin
        @(negedge clk);
        v[k] = 1'b0; s[k] = 1'b0; e[k] = 1'b0;
        @(negedge clk);
      end
    end
    if (tail_idle) begin
      @(negedge clk);
      v[k] = 1'b0; s[k] = 1'b0; e[k] = 1'b0; a[k] = 1'b0;
    end
  endtask

  // Literal expectation for the next strobe in arrival order.
  task automatic expect_st(input string nm, input int k, input logic fe, input logic ru,
                           input logic ov, input logic ab, input int len);
    int cyc;
    cyc = 0;
    while (hist.size() <= ns && cyc < 400) begin
      @(posedge clk);
      #3;
      cyc++;
    end
    if (hist.size() <= ns) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s u%0d: no status strobe within 400 cycles", nm, k);
      return;
    end
    chk({nm, "_lane"}, k, 32'(hist[ns].k), 32'(k));
    chk({nm, "_fcs_error"}, k, 32'(hist[ns].fe), 32'(fe));
    chk({nm, "_runt"}, k, 32'(hist[ns].ru), 32'(ru));
    chk({nm, "_oversize"}, k, 32'(hist[ns].ov), 32'(ov));
    chk({nm, "_aborted"}, k, 32'(hist[ns].ab), 32'(ab));
    chk({nm, "_len"}, k, 32'(hist[ns].len), 32'(len));
    ns++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f, ref9;
    rst = 1'b1;
    d = '0; v = '0; s = '0; e = '0; a = '0; kp = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_status_valid", k, 32'(sv_o[k]), 32'd0);
      chk("reset_fcs_error", k, 32'(fe_o[k]), 32'd0);
      chk("reset_runt", k, 32'(ru_o[k]), 32'd0);
      chk("reset_oversize", k, 32'(ov_o[k]), 32'd0);
      chk("reset_aborted", k, 32'(ab_o[k]), 32'd0);
      chk("reset_frame_len", k, 32'(ln_o[k]), 32'd0);
    end
    rst = 1'b0;

    ref9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("model_crc_check_value", 0, ~crc_of(ref9), 32'hCBF43926);
    f = ref9;
    f.push_back(8'h26); f.push_back(8'h39); f.push_back(8'hF4); f.push_back(8'hCB);
    send(0, f, -1, -1, 0, -1, 1'b1);
    expect_st("ascii_good", 0, 1'b0, 1'b0, 1'b0, 1'b0, 13);
    f[12] = 8'hCA;
    send(0, f, -1, -1, 0, -1, 1'b1);
    expect_st("ascii_bad", 0, 1'b1, 1'b0, 1'b0, 1'b0, 13);
`ifdef FCS_CHECKER_STATS_EN
    chk("stats_good_after_bad", 0, gc_o[0], 32'd1);
    chk("stats_bad_after_bad", 0, bc_o[0], 32'd1);
`endif

    send(1, make_frame(64, 5), 5, -1, 0, -1, 1'b1);
    expect_st("w4_64_gap", 1, 1'b0, 1'b0, 1'b0, 1'b0, 64);

    send(2, make_frame(61, 9), -1, -1, 0, -1, 1'b1);
    expect_st("w8_61_keep5", 2, 1'b0, 1'b1, 1'b0, 1'b0, 61);

    send(1, make_frame(64, 1), -1, 2, 1, -1, 1'b0);
    send(1, make_frame(64, 2), -1, -1, 0, -1, 1'b1);
    expect_st("w4_abort", 1, 1'b1, 1'b1, 1'b0, 1'b1, 8);
    expect_st("w4_after_abort", 1, 1'b0, 1'b0, 1'b0, 1'b0, 64);

    send(1, make_frame(64, 3), -1, 4, 2, -1, 1'b0);
    send(1, make_frame(68, 4), -1, -1, 0, -1, 1'b1);
    expect_st("w4_sof_restart", 1, 1'b1, 1'b1, 1'b0, 1'b1, 20);
    expect_st("w4_after_restart", 1, 1'b0, 1'b0, 1'b0, 1'b0, 68);

    send(1, make_frame(64, 6), -1, -1, 0, 7, 1'b1);
    expect_st("w4_keep7", 1, 1'b0, 1'b0, 1'b0, 1'b0, 64);
    send(2, make_frame(64, 7), -1, -1, 0, 0, 1'b1);
    expect_st("w8_keep0", 2, 1'b0, 1'b0, 1'b0, 1'b0, 64);

    send(1, make_frame(63, 8), -1, -1, 0, -1, 1'b1);
    expect_st("w4_runt63", 1, 1'b0, 1'b1, 1'b0, 1'b0, 63);

    send(2, make_frame(1518, 10), -1, -1, 0, -1, 1'b1);
    expect_st("w8_max", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1518);
    send(2, make_frame(1519, 11), -1, -1, 0, -1, 1'b1);
    expect_st("w8_over", 2, 1'b0, 1'b0, 1'b1, 1'b0, 1519);

    send(2, make_frame(8, 12), -1, -1, 0, -1, 1'b0);
    send(2, make_frame(8, 13), -1, -1, 0, -1, 1'b0);
    send(2, make_frame(16, 14), -1, -1, 0, -1, 1'b1);
    expect_st("w8_single_a", 2, 1'b0, 1'b1, 1'b0, 1'b0, 8);
    expect_st("w8_single_b", 2, 1'b0, 1'b1, 1'b0, 1'b0, 8);
    expect_st("w8_b2b", 2, 1'b0, 1'b1, 1'b0, 1'b0, 16);

    send(1, make_frame(64, 15), -1, 5, 2, -1, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_status_valid", 1, 32'(sv_o[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(1, make_frame(64, 16), -1, -1, 0, -1, 1'b1);
    expect_st("w4_after_reset", 1, 1'b0, 1'b0, 1'b0, 1'b0, 64);

    repeat (4) @(negedge clk);
    chk("strobe_total", 0, 32'(hist.size()), 32'(ns));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
